// File: rtl/spi_slave_if.sv
// SPI pin and local bus bundle for spi_slave.
// The slave modport faces the block; the master modport faces the SPI master and host side.
interface spi_slave_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] din;
  logic       cmd;
  logic       wr;
  logic       rd;
  logic [7:0] dout;
  logic [1:0] status;
  logic       irq;

  modport slave (
    input  sclk, cs_n, mosi, din, cmd, wr, rd,
    output miso, miso_oe, dout, status, irq
  );

  modport master (
    output sclk, cs_n, mosi, din, cmd, wr, rd,
    input  miso, miso_oe, dout, status, irq
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave, all four CPOL/CPHA modes, oversampled on clk.
// Single TX holding register, single RX data register with done/overrun flags.
//
//   state  | meaning
//   IDLE   | cs_s high (or not yet seen high since reset); sclk edges ignored
//   ACTIVE | cs_s low; sampling mosi and shifting tx_sh on sclk edges
module spi_slave (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  logic       sclk_m, sclk_s, sclk_d;
  logic       cs_m, cs_s;
  logic       mosi_m, mosi_s;
  logic [1:0] mode;
  logic       irq_en;
  logic [7:0] tx_hold, tx_sh, rx_sh, rx_data;
  logic [2:0] bit_cnt;
  logic       done, ovr;
  logic [1:0] prime;
  logic       armed;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic in_xfer, byte_done;

  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign lead_edge   = mode[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode[0] ? lead_edge : trail_edge;
  assign in_xfer     = (state == ACTIVE) && !cs_s;
  assign byte_done   = in_xfer && sample_edge && (bit_cnt == 3'd7);

  // The cs synchronizer resets high, so a low cs_n held through reset would
  // look like a falling edge; armed waits for a genuine high sample first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sclk_m  <= 1'b1;
      sclk_s  <= 1'b1;
      sclk_d  <= 1'b1;
      cs_m    <= 1'b1;
      cs_s    <= 1'b1;
      mosi_m  <= 1'b0;
      mosi_s  <= 1'b0;
      mode    <= 2'b00;
      irq_en  <= 1'b0;
      tx_hold <= 8'h00;
      tx_sh   <= 8'h00;
      rx_sh   <= 8'h00;
      rx_data <= 8'h00;
      bit_cnt <= 3'd0;
      done    <= 1'b0;
      ovr     <= 1'b0;
      prime   <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sclk_m <= bus.sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      cs_m   <= bus.cs_n;
      cs_s   <= cs_m;
      mosi_m <= bus.mosi;
      mosi_s <= mosi_m;
      prime  <= {prime[0], 1'b1};
      if ((prime == 2'b11) && cs_s)
        armed <= 1'b1;

      if (bus.cmd && (state != ACTIVE)) begin
        mode   <= bus.din[1:0];
        irq_en <= bus.din[2];
      end
      if (bus.wr)
        tx_hold <= bus.din;

      case (state)
        IDLE: begin
          if (armed && !cs_s) begin
            state   <= ACTIVE;
            tx_sh   <= tx_hold;
            bit_cnt <= 3'd0;
            rx_sh   <= 8'h00;
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
          end else if (sample_edge) begin
            rx_sh   <= {rx_sh[6:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              rx_data <= {rx_sh[6:0], mosi_s};
          end else if (shift_edge) begin
            if (bit_cnt == 3'd0)
              tx_sh <= tx_hold;
            else
              tx_sh <= {tx_sh[6:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase

      // A completing byte wins over a coincident read acknowledge.
      if (byte_done) begin
        done <= 1'b1;
        if (done && !bus.rd)
          ovr <= 1'b1;
      end else if (bus.rd) begin
        done <= 1'b0;
        ovr  <= 1'b0;
      end
    end
  end

  assign bus.miso    = tx_sh[7];
  assign bus.miso_oe = ~cs_s;
  assign bus.dout    = rx_data;
  assign bus.status  = {ovr, done};
  assign bus.irq     = irq_en & done;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged SPI master plus host bus strobes,
// with hand-computed expectations checked by immediate assertions.
module tb_spi_slave;
  localparam int H = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [7:0] rx;

  spi_slave_if bus ();

  spi_slave dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [7:0] v);
    bus.din = v; bus.cmd = 1'b1; wait_clk(1);
    bus.cmd = 1'b0; wait_clk(1);
  endtask

  task automatic do_wr(input logic [7:0] v);
    bus.din = v; bus.wr = 1'b1; wait_clk(1);
    bus.wr = 1'b0; wait_clk(1);
  endtask

  task automatic do_rd();
    bus.rd = 1'b1; wait_clk(1);
    bus.rd = 1'b0; wait_clk(1);
  endtask

  task automatic cs_lo();
    bus.cs_n = 1'b0; wait_clk(H);
  endtask

  task automatic cs_hi();
    bus.cs_n = 1'b1; wait_clk(H);
  endtask

  // Master: sends tx MSB first for nbits, returns what it captured from miso.
  // rd_last pulses rd in the exact cycle the slave completes the last sample.
  task automatic xfer(input bit cpol, input bit cpha, input logic [7:0] tx,
                      input int nbits, input bit rd_last, output logic [7:0] rxo);
    rxo = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        bus.mosi = tx[7-i];
        wait_clk(H);
        bus.sclk = ~cpol;
        rxo = {rxo[6:0], bus.miso};
        if (rd_last && (i == nbits - 1)) begin
          wait_clk(2);
          bus.rd = 1'b1;
          wait_clk(1);
          bus.rd = 1'b0;
          wait_clk(H - 3);
        end else begin
          wait_clk(H);
        end
        bus.sclk = cpol;
      end else begin
        bus.sclk = ~cpol;
        bus.mosi = tx[7-i];
        wait_clk(H);
        bus.sclk = cpol;
        rxo = {rxo[6:0], bus.miso};
        wait_clk(H);
      end
    end
    if (!cpha) wait_clk(H);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.din  = 8'h00;
    bus.cmd  = 1'b0;
    bus.wr   = 1'b0;
    bus.rd   = 1'b0;
    wait_clk(3);
    chk("reset_dout", bus.dout, 8'h00);
    chk("reset_pins", {4'b0, bus.miso, bus.miso_oe, bus.status}, 8'h00);
    chk("reset_irq", 8'(bus.irq), 8'h00);
    rst = 1'b0;
    wait_clk(4);

    // Mode 0, irq enabled
    do_cmd(8'h04);
    do_wr(8'hA5);
    cs_lo();
    chk("m0_oe", 8'(bus.miso_oe), 8'h01);
    xfer(1'b0, 1'b0, 8'h3C, 8, 1'b0, rx);
    cs_hi();
    chk("m0_miso", rx, 8'hA5);
    chk("m0_dout", bus.dout, 8'h3C);
    chk("m0_status", 8'(bus.status), 8'h01);
    chk("m0_irq", 8'(bus.irq), 8'h01);
    do_rd();
    chk("m0_status_rd", 8'(bus.status), 8'h00);
    chk("m0_irq_rd", 8'(bus.irq), 8'h00);

    // Mode 3
    bus.sclk = 1'b1;
    wait_clk(4);
    do_cmd(8'h03);
    do_wr(8'h81);
    cs_lo();
    xfer(1'b1, 1'b1, 8'hF0, 8, 1'b0, rx);
    cs_hi();
    chk("m3_miso", rx, 8'h81);
    chk("m3_dout", bus.dout, 8'hF0);
    chk("m3_irq", 8'(bus.irq), 8'h00);
    do_rd();

    // Mode 1, two bytes in one select, refill between bytes
    bus.sclk = 1'b0;
    wait_clk(4);
    do_cmd(8'h01);
    do_wr(8'h55);
    cs_lo();
    xfer(1'b0, 1'b1, 8'h12, 8, 1'b0, rx);
    chk("m1_b1_miso", rx, 8'h55);
    chk("m1_b1_status", 8'(bus.status), 8'h01);
    do_wr(8'hAA);
    xfer(1'b0, 1'b1, 8'h34, 8, 1'b0, rx);
    cs_hi();
    chk("m1_b2_miso", rx, 8'hAA);
    chk("m1_dout", bus.dout, 8'h34);
    chk("m1_status_ovr", 8'(bus.status), 8'h03);
    do_rd();
    chk("m1_status_rd", 8'(bus.status), 8'h00);

    // rd coinciding with completion while done is already set
    do_cmd(8'h00);
    cs_lo();
    xfer(1'b0, 1'b0, 8'h11, 8, 1'b0, rx);
    cs_hi();
    chk("rdc_pre_status", 8'(bus.status), 8'h01);
    cs_lo();
    xfer(1'b0, 1'b0, 8'h22, 8, 1'b1, rx);
    cs_hi();
    chk("rdc_status", 8'(bus.status), 8'h01);
    chk("rdc_dout", bus.dout, 8'h22);
    do_rd();

    // Mode 2 with cmd and wr in the same cycle; partial byte then full byte
    bus.sclk = 1'b1;
    wait_clk(4);
    bus.din = 8'hAE; bus.cmd = 1'b1; bus.wr = 1'b1;
    wait_clk(1);
    bus.cmd = 1'b0; bus.wr = 1'b0;
    wait_clk(1);
    cs_lo();
    xfer(1'b1, 1'b0, 8'hFF, 5, 1'b0, rx);
    cs_hi();
    chk("m2_part_status", 8'(bus.status), 8'h00);
    chk("m2_part_dout", bus.dout, 8'h22);
    cs_lo();
    xfer(1'b1, 1'b0, 8'h7E, 8, 1'b0, rx);
    cs_hi();
    chk("m2_miso", rx, 8'hAE);
    chk("m2_dout", bus.dout, 8'h7E);
    chk("m2_status", 8'(bus.status), 8'h01);
    chk("m2_irq", 8'(bus.irq), 8'h01);
    do_rd();

    // cmd during ACTIVE must be ignored
    bus.sclk = 1'b0;
    wait_clk(4);
    do_cmd(8'h00);
    do_wr(8'h96);
    cs_lo();
    do_cmd(8'h07);
    xfer(1'b0, 1'b0, 8'h5B, 8, 1'b0, rx);
    cs_hi();
    chk("act_cmd_miso", rx, 8'h96);
    chk("act_cmd_dout", bus.dout, 8'h5B);
    chk("act_cmd_irq", 8'(bus.irq), 8'h00);
    do_rd();

    // rst mid-byte, then no re-entry without a fresh cs_n fall
    cs_lo();
    xfer(1'b0, 1'b0, 8'hFF, 4, 1'b0, rx);
    rst = 1'b1;
    wait_clk(2);
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_pins", {4'b0, bus.miso, bus.miso_oe, bus.status}, 8'h00);
    chk("rst_irq", 8'(bus.irq), 8'h00);
    rst = 1'b0;
    wait_clk(4);
    xfer(1'b0, 1'b0, 8'hFF, 8, 1'b0, rx);
    chk("rst_noentry_status", 8'(bus.status), 8'h00);
    chk("rst_noentry_dout", bus.dout, 8'h00);
    cs_hi();
    do_wr(8'hC3);
    cs_lo();
    xfer(1'b0, 1'b0, 8'h5A, 8, 1'b0, rx);
    cs_hi();
    chk("post_rst_miso", rx, 8'hC3);
    chk("post_rst_dout", bus.dout, 8'h5A);
    chk("post_rst_status", 8'(bus.status), 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
